neuron_sequencer: RTL

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_seq_if.sv | 26 ++
 rtl/neuron_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/neuron_seq_if.sv
// rtl/neuron_seq_if.sv - sample source, neuron and result channels of the neuron sequencer
interface neuron_seq_if #(
  parameter int N = 16
);
  logic         src_valid;
  logic [N-1:0] src_data;
  logic         src_ready;
  logic [N-1:0] n_x;
  logic         n_ld;
  logic         n_st;
  logic         n_done;
  logic [N-1:0] n_y;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_ready;

  modport master (
    input  src_valid, src_data, n_done, n_y, res_ready,
    output src_ready, n_x, n_ld, n_st, res_valid, res_data
  );

  modport slave (
    output src_valid, src_data, n_done, n_y, res_ready,
    input  src_ready, n_x, n_ld, n_st, res_valid, res_data
  );
endinterface

// File: rtl/neuron_sequencer.sv
// rtl/neuron_sequencer.sv - feeds d samples per evaluation to a neuron and emits Q results per run
// Optional WAIT watchdog (sticky o_err) is built when NEURON_SEQ_TIMEOUT_EN is defined.
module neuron_sequencer #(
  parameter int N   = 16,
  parameter int Q   = 100,
  parameter int d   = 3,
  parameter int TMO = 1023
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_go,
  neuron_seq_if.master io_bus,
  output logic         o_busy,
  output logic         o_run_done,
  output logic         o_err
);

  localparam int KW = $clog2(d + 1);
  localparam int EW = $clog2(Q + 1);
  localparam logic [KW-1:0] K_LAST = KW'(d - 1);
  localparam logic [EW-1:0] E_LAST = EW'(Q - 1);

  if (N < 1 || Q < 1 || d < 1 || TMO < 2) begin : g_bad_params
    $error("neuron_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT, S_EMIT, S_FINISH
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [EW-1:0] r_e;
  logic [N-1:0]  r_n_x;
  logic          r_n_ld;
  logic          r_n_st;
  logic          r_src_ready;
  logic          r_res_valid;
  logic [N-1:0]  r_res_data;
  logic          r_busy;
  logic          r_run_done;

  logic w_src_hs;
  logic w_res_hs;
  logic w_wd_expired;
  logic w_take_done;

`ifdef NEURON_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TMO - 1);
  localparam logic [TW-1:0] WD_WARN = TW'(TMO - 2);

  logic [TW-1:0] r_wd;
  logic          r_err;

  assign w_wd_expired = (r_wd == WD_LAST);
  assign o_err        = r_err;
`else
  assign w_wd_expired = 1'b0;
  assign o_err        = 1'b0;
`endif

  assign w_src_hs    = io_bus.src_valid & r_src_ready;
  assign w_res_hs    = r_res_valid & io_bus.res_ready;
  // a done level still high from the previous evaluation is masked while the start pulse is out
  assign w_take_done = io_bus.n_done & ~r_n_st & ~w_wd_expired;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_e         <= '0;
      r_n_x       <= '0;
      r_n_ld      <= 1'b0;
      r_n_st      <= 1'b0;
      r_src_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_run_done  <= 1'b0;
`ifdef NEURON_SEQ_TIMEOUT_EN
      r_wd        <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_n_ld     <= 1'b0;
      r_n_st     <= 1'b0;
      r_run_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_go) begin
            r_state     <= S_FETCH;
            r_k         <= '0;
            r_e         <= '0;
            r_src_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          if (w_src_hs) begin
            r_n_x  <= io_bus.src_data;
            r_n_ld <= 1'b1;
            r_k    <= r_k + KW'(1);
            if (r_k == K_LAST) begin
              r_src_ready <= 1'b0;
              r_state     <= S_START;
            end
          end
        end
        S_START: begin
          r_n_st  <= 1'b1;
          r_state <= S_WAIT;
`ifdef NEURON_SEQ_TIMEOUT_EN
          r_wd    <= '0;
`endif
        end
        S_WAIT: begin
          if (w_take_done) begin
            r_res_data  <= io_bus.n_y;
            r_res_valid <= 1'b1;
            r_state     <= S_EMIT;
          end
`ifdef NEURON_SEQ_TIMEOUT_EN
          else if (w_wd_expired) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wd <= r_wd + TW'(1);
            // err is raised one cycle ahead of the abort so it is visible in the last WAIT cycle
            if (r_wd == WD_WARN) begin
              r_err <= 1'b1;
            end
          end
`endif
        end
        S_EMIT: begin
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_e         <= r_e + EW'(1);
            if (r_e == E_LAST) begin
              r_state    <= S_FINISH;
              r_run_done <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_k         <= '0;
              r_src_ready <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_src_ready <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.src_ready = r_src_ready;
  assign io_bus.n_x       = r_n_x;
  assign io_bus.n_ld      = r_n_ld;
  assign io_bus.n_st      = r_n_st;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_data  = r_res_data;
  assign o_busy           = r_busy;
  assign o_run_done       = r_run_done;

endmodule
